// File: rtl/mcp3202_seq.sv
// rtl/mcp3202_seq.sv - MCP3202 frame sequencer: paces conversions on an external
// SPI core and buffers tagged results in a 2-entry output FIFO.
module mcp3202_seq #(
  parameter int   FCLK  = 100_000_000,
  parameter int   FSMPL = 500,
  parameter logic SGL   = 1'b1,
  parameter int   TMO   = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ch_en,
  output logic        spi_start,
  output logic        spi_sgl,
  output logic        spi_odd,
  input  logic        spi_busy,
  input  logic        spi_dv,
  input  logic [11:0] spi_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [11:0] m_data,
  output logic        m_chan,
  output logic        overrun,
  output logic        frame_miss,
  output logic        timeout,
  input  logic        clr_flags
);

  localparam int PER = FCLK / FSMPL;
  localparam int PW  = (PER > 1) ? $clog2(PER) : 1;
  localparam int TW  = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_DV = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_en_q1;
  logic          r_chan;
  logic          r_start;
  logic          r_overrun;
  logic          r_frame_miss;
  logic          r_timeout;

  logic          w_frame_go;
  logic          w_fire;
  logic          w_push;
  logic          w_tmo_hit;
  logic          w_fmiss;

  logic [12:0]   r_mem [2];
  logic          r_wr;
  logic          r_rd;
  logic [1:0]    r_cnt;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_ovr;

  // Free-running frame pacer, independent of the sequencer state.
  assign w_tick = (r_tick_cnt == PW'(PER - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_tick && (ch_en != 2'b00)) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!spi_busy) begin
          w_state_nxt = S_WAIT_DV;
        end
      end
      S_WAIT_DV: begin
        if (spi_dv) begin
          w_state_nxt = (!r_chan && r_en_q1) ? S_ISSUE : S_IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_frame_go = 1'b0;
    w_fire     = 1'b0;
    w_push     = 1'b0;
    w_tmo_hit  = 1'b0;
    w_fmiss    = 1'b0;
    case (r_state)
      S_IDLE:    w_frame_go = w_tick;
      S_ISSUE: begin
        w_fire  = !spi_busy;
        w_fmiss = w_tick;
      end
      S_WAIT_DV: begin
        w_push    = spi_dv;
        w_tmo_hit = !spi_dv && (r_tmo_cnt == TW'(1));
        w_fmiss   = w_tick;
      end
      default: w_fmiss = w_tick;
    endcase
  end

  // Channel only moves on a frame start or on the CH0->CH1 hand-off, so spi_odd
  // holds steady across each conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q1 <= 1'b0;
      r_chan  <= 1'b0;
    end else if (w_frame_go) begin
      r_en_q1 <= ch_en[1];
      if (ch_en != 2'b00) begin
        r_chan <= ~ch_en[0];
      end
    end else if (w_push && !r_chan && r_en_q1) begin
      r_chan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start   <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_start <= w_fire;
      if (w_fire) begin
        r_tmo_cnt <= TW'(TMO);
      end else if ((r_state == S_WAIT_DV) && (r_tmo_cnt != '0)) begin
        r_tmo_cnt <= r_tmo_cnt - TW'(1);
      end
    end
  end

  assign w_full  = (r_cnt == 2'd2);
  assign w_pop   = (r_cnt != 2'd0) && m_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_ovr   = w_push && w_full && !w_pop;

  // When full, the write slot equals the read slot being popped this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= {r_chan, spi_data};
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun    <= 1'b0;
      r_frame_miss <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_overrun    <= w_ovr     | (r_overrun    & ~clr_flags);
      r_frame_miss <= w_fmiss   | (r_frame_miss & ~clr_flags);
      r_timeout    <= w_tmo_hit | (r_timeout    & ~clr_flags);
    end
  end

  assign spi_start  = r_start;
  assign spi_sgl    = SGL;
  assign spi_odd    = r_chan;
  assign m_valid    = (r_cnt != 2'd0);
  assign m_data     = r_mem[r_rd][11:0];
  assign m_chan     = r_mem[r_rd][12];
  assign overrun    = r_overrun;
  assign frame_miss = r_frame_miss;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_mcp3202_seq.sv
// tb/tb_mcp3202_seq.sv - directed bench for mcp3202_seq with a delay-based
// SPI core model and start/pop monitors.
module tb_mcp3202_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_en;
  logic        spi_start;
  logic        spi_sgl;
  logic        spi_odd;
  logic        spi_busy;
  logic        spi_dv;
  logic [11:0] spi_data;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_data;
  logic        m_chan;
  logic        overrun;
  logic        frame_miss;
  logic        timeout;
  logic        clr_flags;

  logic        core_busy;
  logic        force_busy;
  logic        core_en;
  logic        core_ch;
  int          core_cnt;
  int          core_dly;

  int          cyc;
  int          n_chk;
  int          n_err;
  int          rel;
  int          s0;
  int          s1;
  int          st_cyc[$];
  logic        st_odd[$];
  logic [12:0] pop_q[$];
  int          pop_cyc[$];

  always #5 clk = ~clk;

  assign spi_busy = core_busy | force_busy;

  mcp3202_seq #(
    .FCLK (1_000_000),
    .FSMPL(1000),
    .SGL  (1'b1),
    .TMO  (200)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .spi_start (spi_start),
    .spi_sgl   (spi_sgl),
    .spi_odd   (spi_odd),
    .spi_busy  (spi_busy),
    .spi_dv    (spi_dv),
    .spi_data  (spi_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_chan    (m_chan),
    .overrun   (overrun),
    .frame_miss(frame_miss),
    .timeout   (timeout),
    .clr_flags (clr_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Core model: dv core_dly cycles after the start pulse, data chosen by spi_odd.
  initial begin
    core_cnt  = 0;
    core_busy = 1'b0;
    core_ch   = 1'b0;
    spi_dv    = 1'b0;
    spi_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      spi_dv = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          spi_dv    = 1'b1;
          spi_data  = core_ch ? 12'h4E8 : 12'h75F;
          core_busy = 1'b0;
        end
      end else if (spi_start && core_en) begin
        core_cnt  = core_dly;
        core_ch   = spi_odd;
        core_busy = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (spi_start) begin
        st_cyc.push_back(cyc);
        st_odd.push_back(spi_odd);
      end
      if (m_valid && m_ready) begin
        pop_q.push_back({m_chan, m_data});
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset(input logic [1:0] en);
    @(posedge clk);
    #1 rst = 1'b1;
    ch_en = en;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    st_cyc.delete();
    st_odd.delete();
    pop_q.delete();
    pop_cyc.delete();
  endtask

  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_starts(input int n, input int lim);
    int k = 0;
    while (st_cyc.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("wait_starts", st_cyc.size() >= n, 1);
  endtask

  task automatic wait_pops(input int n, input int lim);
    int k = 0;
    while (pop_q.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("wait_pops", pop_q.size() >= n, 1);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b1;
    ch_en      = 2'b00;
    m_ready    = 1'b1;
    clr_flags  = 1'b0;
    force_busy = 1'b0;
    core_en    = 1'b1;
    core_dly   = 50;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start", spi_start, 0);
    check("rst_sgl", spi_sgl, 1);
    check("rst_outs", {m_valid, m_chan, m_data, spi_odd, overrun, frame_miss, timeout}, 0);

    // Both channels, free-flowing output.
    do_reset(2'b11);
    wait_pops(4, 2300);
    if (pop_q.size() >= 4 && st_cyc.size() >= 3) begin
      check("A_first_start", st_cyc[0] - rel, 1001);
      check("A_ch1_start", st_cyc[1] - st_cyc[0], 52);
      check("A_frame_gap", st_cyc[2] - st_cyc[0], 1000);
      check("A_valid_lat", pop_cyc[0] - st_cyc[0], 51);
      check("A_odd", {st_odd[0], st_odd[1]}, 2'b01);
      check("A_pop0", pop_q[0], {1'b0, 12'h75F});
      check("A_pop1", pop_q[1], {1'b1, 12'h4E8});
      check("A_pop2", pop_q[2], {1'b0, 12'h75F});
      check("A_pop3", pop_q[3], {1'b1, 12'h4E8});
    end
    check("A_flags", {overrun, frame_miss, timeout}, 0);

    // CH1 only.
    do_reset(2'b10);
    wait_starts(2, 2300);
    at_cyc(rel + 2150);
    check("B_nstarts", st_cyc.size(), 2);
    check("B_npops", pop_q.size(), 2);
    if (st_cyc.size() >= 2 && pop_q.size() >= 2) begin
      check("B_odd", {st_odd[0], st_odd[1]}, 2'b11);
      check("B_pop0", pop_q[0], {1'b1, 12'h4E8});
      check("B_pop1", pop_q[1], {1'b1, 12'h4E8});
    end

    // No channels.
    do_reset(2'b00);
    at_cyc(rel + 3100);
    check("B_none_starts", st_cyc.size(), 0);
    check("B_none_valid", m_valid, 0);

    // Back-pressure: FIFO fills on frame 1, frame 2 overruns.
    m_ready = 1'b0;
    do_reset(2'b11);
    at_cyc(rel + 1500);
    check("C_full_head", {m_valid, m_chan, m_data}, {1'b1, 1'b0, 12'h75F});
    check("C_no_ovr_yet", overrun, 0);
    at_cyc(rel + 2200);
    check("C_nstarts", st_cyc.size(), 4);
    check("C_hold_head", {m_valid, m_chan, m_data}, {1'b1, 1'b0, 12'h75F});
    check("C_ovr", {overrun, frame_miss, timeout}, 3'b100);
    @(posedge clk);
    #1 m_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("C_npops", pop_q.size(), 2);
    if (pop_q.size() >= 2) begin
      check("C_pop0", pop_q[0], {1'b0, 12'h75F});
      check("C_pop1", pop_q[1], {1'b1, 12'h4E8});
    end
    check("C_empty", m_valid, 0);

    // Core never answers: timeout, recovery, clear, set-beats-clear.
    core_en = 1'b0;
    do_reset(2'b01);
    wait_starts(1, 1100);
    s0 = st_cyc[0];
    at_cyc(s0 + 199);
    check("D_tmo_early", timeout, 0);
    at_cyc(s0 + 200);
    check("D_tmo", timeout, 1);
    wait_starts(2, 1100);
    s1 = st_cyc[1];
    check("D_restart_gap", s1 - s0, 1000);
    @(posedge clk);
    #1 clr_flags = 1'b1;
    @(negedge clk);
    check("D_clr_same", timeout, 1);
    @(posedge clk);
    #1 clr_flags = 1'b0;
    @(negedge clk);
    check("D_clr", timeout, 0);
    at_cyc(s1 + 195);
    @(posedge clk);
    #1 clr_flags = 1'b1;
    at_cyc(s1 + 199);
    check("D_tmo2_early", timeout, 0);
    @(posedge clk);
    #1 clr_flags = 1'b0;
    @(negedge clk);
    check("D_set_wins", timeout, 1);
    check("D_no_pops", pop_q.size(), 0);
    core_en = 1'b1;

    // Frame still in progress (stalled in ISSUE) when the next tick arrives.
    force_busy = 1'b1;
    do_reset(2'b01);
    at_cyc(rel + 1999);
    check("E_fm_early", frame_miss, 0);
    check("E_no_start", st_cyc.size(), 0);
    at_cyc(rel + 2000);
    check("E_fm", frame_miss, 1);
    at_cyc(rel + 2004);
    @(posedge clk);
    #1 force_busy = 1'b0;
    wait_starts(1, 20);
    if (st_cyc.size() >= 1) check("E_start_at", st_cyc[0] - rel, 2006);
    wait_pops(1, 100);
    if (pop_q.size() >= 1) check("E_pop0", pop_q[0], {1'b0, 12'h75F});
    at_cyc(rel + 2900);
    check("E_one_start", st_cyc.size(), 1);

    // Reset mid-conversion; the late dv must be ignored.
    do_reset(2'b01);
    wait_starts(1, 1100);
    s0 = st_cyc[0];
    at_cyc(s0 + 9);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    at_cyc(s0 + 60);
    check("F_outs", {spi_start, m_valid, m_chan, m_data, spi_odd, overrun, frame_miss, timeout}, 0);
    check("F_no_pop", pop_q.size(), 0);
    wait_starts(2, 1100);
    if (st_cyc.size() >= 2) check("F_restart", st_cyc[1] - rel, 1001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mcp3202_seq.md
MCP3202_SEQ -- requirements
Module: mcp3202_seq

Interface
REQ-001 Parameter FCLK, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter FSMPL, default 500, frame rate in Hz; each enabled channel is sampled once per frame.
REQ-003 Parameter SGL, default 1, value driven on spi_sgl (1 = single-ended, 0 = differential).
REQ-004 Parameter TMO, default 20000, maximum clk cycles from spi_start to spi_dv before timeout.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ch_en  in  2  channel enable mask (bit0 = CH0, bit1 = CH1), sampled at frame tick only.
REQ-008 spi_start  out  1  one-cycle pulse requesting one conversion from the SPI conversion core.
REQ-009 spi_sgl  out  1  SGL/DIFF bit for the core; constant = SGL.
REQ-010 spi_odd  out  1  ODD/SIGN (channel) bit for the core; stable from spi_start until spi_dv or timeout.
REQ-011 spi_busy  in  1  core busy; high while a conversion is in progress.
REQ-012 spi_dv  in  1  one-cycle pulse, conversion complete; spi_data valid in that cycle.
REQ-013 spi_data  in  12  conversion result.
REQ-014 m_valid  out  1  output sample available.
REQ-015 m_ready  in  1  downstream accepts sample.
REQ-016 m_data  out  12  output sample value.
REQ-017 m_chan  out  1  channel tag of m_data.
REQ-018 overrun  out  1  sticky: sample dropped because output buffer full.
REQ-019 frame_miss  out  1  sticky: frame tick occurred while a frame was still in progress.
REQ-020 timeout  out  1  sticky: spi_dv not received within TMO cycles.
REQ-021 clr_flags  in  1  clears overrun, frame_miss and timeout the following cycle.

Function
REQ-022 Tick counter: counts 0..PER-1, PER = FCLK/FSMPL (integer division), wraps to 0; tick asserted in the cycle count == PER-1; free-running, not gated by FSM.
REQ-023 FSM states: IDLE, ISSUE, WAIT_DV.
REQ-024 IDLE: on tick, latch ch_en into en_q; en_q == 0 -> stay IDLE, no conversion; else -> ISSUE with chan = lowest enabled channel.
REQ-025 ISSUE: when spi_busy == 0, assert spi_start for exactly one cycle with spi_odd = chan, load timeout counter, -> WAIT_DV; when spi_busy == 1, hold in ISSUE with spi_start low.
REQ-026 WAIT_DV: on spi_dv, push {chan, spi_data} to output buffer; if chan == 0 and en_q[1] == 1 -> ISSUE with chan = 1; else -> IDLE.
REQ-027 WAIT_DV timeout: after TMO cycles without spi_dv, set timeout, abandon remaining channels of frame, -> IDLE.
REQ-028 spi_dv outside WAIT_DV is ignored (no push, no state change).
REQ-029 Tick while FSM not IDLE: set frame_miss, tick discarded, current frame continues; no new frame queued.
REQ-030 Latency: tick in cycle t (FSM IDLE, spi_busy low) -> spi_start high in cycle t+2 (ISSUE entered t+1, start registered); push at spi_dv cycle d -> m_valid high at d+1 if buffer was empty.
REQ-031 Output buffer: 2-entry FIFO of {chan, data}; m_valid = not empty; m_data/m_chan show oldest entry; pop when m_valid & m_ready.
REQ-032 Push when full without simultaneous pop: new sample dropped, FIFO unchanged, overrun set.
REQ-033 Push and pop in same cycle when full: both performed, no overrun.
REQ-034 m_data/m_chan stable while m_valid & ~m_ready.
REQ-035 clr_flags in same cycle as a flag-setting event: set wins.

Reset
REQ-036 rst: FSM -> IDLE, tick counter = 0, en_q = 0, FIFO empty, timeout counter = 0.
REQ-037 Output reset values: spi_start 0, spi_odd 0, m_valid 0, m_data 0, m_chan 0, overrun 0, frame_miss 0, timeout 0; spi_sgl = SGL.
REQ-038 rst mid-conversion: spi_start low next cycle, late spi_dv ignored, no sample pushed.

Verification (FCLK=1_000_000, FSMPL=1000 -> PER=1000, TMO=200)
REQ-039 ch_en=2'b11, core model returns dv 50 cycles after start, CH0=12'h75F, CH1=12'h4E8, m_ready=1 -> per frame m_chan/m_data = 0/75F then 1/4E8, spi_start spaced 1000 cycles frame-to-frame, no flags.
REQ-040 ch_en=2'b10 -> one conversion per frame, spi_odd=1, m_chan=1; ch_en=2'b00 -> no spi_start for 3 frames.
REQ-041 m_ready=0, ch_en=2'b11, 2 frames -> FIFO holds 0/75F, 1/4E8 from frame 1; frame 2 samples dropped, overrun=1; raise m_ready -> exactly 2 pops, m_valid then 0.
REQ-042 Core never returns spi_dv -> timeout=1 at start+200 cycles, FSM IDLE, next tick issues new spi_start; clr_flags pulse -> timeout=0.
REQ-043 Core dv delay 1100 cycles (TMO raised to 2000) -> frame_miss=1 at next tick, no second overlapping spi_start.
REQ-044 rst pulsed 10 cycles after spi_start, core later pulses spi_dv -> m_valid stays 0, all outputs at reset values, next spi_start 1001 cycles after rst release.
